dmem_port_arbiter: RTL

- Shares the single data_memory port (including the serial MMIO window) between two requesters: the processor load/store path and a DMA/debug loader.
- Sits between the processor's ALU-address/store-data/MemRead/MemWrite signals and data_memory.
- Returns a stall to the processor, which holds pc and register write-back while stalled.
- Fixed CPU priority, with bounded DMA starvation and bounded DMA burst length.

---
 rtl/dmem_arb_pkg.sv | 25 ++
 rtl/dmem_arb_pick.sv | 44 ++++
 rtl/dmem_port_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dmem_arb_pkg
// Desc     : Shared encodings and default limits for the data-memory arbiter.
// Revision : 1.0
// ============================================================================
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CPU_RD = 2'd1,
        ST_DMA_RD = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_CPU  = 2'd1,
        WIN_DMA  = 2'd2
    } win_t;

    localparam int STARVE_LIMIT_DEF  = 8;
    localparam int DMA_BURST_MAX_DEF = 4;

endpackage
`default_nettype wire

// File: rtl/dmem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pick
// Desc     : Combinational winner selection: CPU first, unless a starved DMA
//            must be forced a slot; DMA bursts capped while the CPU waits.
// Revision : 1.0
// ============================================================================
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT  = STARVE_LIMIT_DEF,
    parameter int DMA_BURST_MAX = DMA_BURST_MAX_DEF,
    parameter int STARVE_W      = $clog2(STARVE_LIMIT + 1),
    parameter int BURST_W       = $clog2(DMA_BURST_MAX + 1)
) (
    input  logic                cpu_req,
    input  logic                dma_req,
    input  logic [STARVE_W-1:0] starve_cnt,
    input  logic [BURST_W-1:0]  burst_cnt,
    output win_t                winner
);

    localparam logic [STARVE_W-1:0] C_STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [BURST_W-1:0]  C_BURST_MAX  = BURST_W'(DMA_BURST_MAX);

    logic w_dma_forced;
    logic w_burst_ok;

    assign w_dma_forced = dma_req && (starve_cnt == C_STARVE_MAX);
    assign w_burst_ok   = burst_cnt < C_BURST_MAX;

    always_comb begin
        winner = WIN_NONE;
        if (cpu_req && !w_dma_forced) begin
            winner = WIN_CPU;
        end else if (dma_req && w_burst_ok) begin
            winner = WIN_DMA;
        end else if (dma_req && !cpu_req) begin
            winner = WIN_DMA;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_arbiter
// Desc     : Shares the single data_memory port between the CPU load/store
//            path and a DMA/debug loader. Define ARB_PERF_CNT_EN to enable
//            the stall-cycle and DMA-transfer performance counters.
// Revision : 1.0
// ============================================================================
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int STARVE_LIMIT  = STARVE_LIMIT_DEF,
    parameter int DMA_BURST_MAX = DMA_BURST_MAX_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [1:0]        dma_size,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_size,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       perf_cpu_stall,
    output logic [31:0]       perf_dma_xfers
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int BURST_W  = $clog2(DMA_BURST_MAX + 1);
    localparam logic [STARVE_W-1:0] C_STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [BURST_W-1:0]  C_BURST_MAX  = BURST_W'(DMA_BURST_MAX);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    win_t                w_winner;
    logic [STARVE_W-1:0] r_starve_cnt;
    logic [BURST_W-1:0]  r_burst_cnt;
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic [DATA_W-1:0]   r_dma_rdata;
    logic                w_cpu_grant;

    dmem_arb_pick #(
        .STARVE_LIMIT  (STARVE_LIMIT),
        .DMA_BURST_MAX (DMA_BURST_MAX),
        .STARVE_W      (STARVE_W),
        .BURST_W       (BURST_W)
    ) u_pick (
        .cpu_req    (cpu_req),
        .dma_req    (dma_req),
        .starve_cnt (r_starve_cnt),
        .burst_cnt  (r_burst_cnt),
        .winner     (w_winner)
    );

    assign w_cpu_grant = (r_state == ST_IDLE) && (w_winner == WIN_CPU);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outputs are all held at zero while reset is asserted, including the
    // read-data holding registers and the stall.
    always_comb begin
        w_state_nxt = ST_IDLE;
        cpu_rdata   = '0;
        cpu_rvalid  = 1'b0;
        cpu_stall   = 1'b0;
        dma_gnt     = 1'b0;
        dma_rdata   = '0;
        dma_rvalid  = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_size    = 2'd0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        if (reset) begin
            cpu_rdata = r_cpu_rdata;
            dma_rdata = r_dma_rdata;
            case (r_state)
                ST_IDLE: begin
                    cpu_stall = cpu_req;
                    if (w_winner == WIN_CPU) begin
                        mem_addr  = cpu_addr;
                        mem_wdata = cpu_wdata;
                        mem_size  = cpu_size;
                        mem_we    = cpu_we;
                        mem_re    = ~cpu_we;
                        cpu_stall = ~cpu_we;
                        if (!cpu_we) begin
                            w_state_nxt = ST_CPU_RD;
                        end
                    end else if (w_winner == WIN_DMA) begin
                        mem_addr  = dma_addr;
                        mem_wdata = dma_wdata;
                        mem_size  = dma_size;
                        mem_we    = dma_we;
                        mem_re    = ~dma_we;
                        dma_gnt   = 1'b1;
                        if (!dma_we) begin
                            w_state_nxt = ST_DMA_RD;
                        end
                    end
                end
                ST_CPU_RD: begin
                    cpu_rvalid = 1'b1;
                    cpu_rdata  = mem_rdata;
                end
                ST_DMA_RD: begin
                    dma_rvalid = 1'b1;
                    dma_rdata  = mem_rdata;
                    cpu_stall  = cpu_req;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
        end else begin
            if (cpu_rvalid) begin
                r_cpu_rdata <= mem_rdata;
            end
            if (dma_rvalid) begin
                r_dma_rdata <= mem_rdata;
            end
        end
    end

    // Starvation only accrues on IDLE cycles where the DMA actually lost.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_starve_cnt <= '0;
            r_burst_cnt  <= '0;
        end else begin
            if (dma_gnt || !dma_req) begin
                r_starve_cnt <= '0;
            end else if ((r_state == ST_IDLE) && (r_starve_cnt != C_STARVE_MAX)) begin
                r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
            end

            if (!cpu_req || w_cpu_grant) begin
                r_burst_cnt <= '0;
            end else if (dma_gnt && (r_burst_cnt != C_BURST_MAX)) begin
                r_burst_cnt <= r_burst_cnt + BURST_W'(1);
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_xfers;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_perf_stall <= 32'd0;
            r_perf_xfers <= 32'd0;
        end else begin
            if (cpu_stall) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (dma_gnt) begin
                r_perf_xfers <= r_perf_xfers + 32'd1;
            end
        end
    end

    assign perf_cpu_stall = reset ? r_perf_stall : 32'd0;
    assign perf_dma_xfers = reset ? r_perf_xfers : 32'd0;
`else
    assign perf_cpu_stall = 32'd0;
    assign perf_dma_xfers = 32'd0;
`endif

endmodule
`default_nettype wire
